// File: rtl/mux_bus_arbiter.sv
// rtl/mux_bus_arbiter.sv - two-requester round-robin burst arbiter driving an 8-bit 2:1 byte-lane mux
//
// Purpose:
//   Decides which of two requesters owns the shared memory-side byte lane.
//   Each grant lasts one burst of len+1 beats. After a burst completes, priority
//   passes to the other requester. One IDLE cycle always separates bursts.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a stall counter watches OWN cycles that have no accepted beat.
//   When the counter reaches TIMEOUT, ownership is revoked and a one-cycle
//   'timeout' pulse is produced.
//   When undefined, there is no stall counter and no 'timeout' port.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req0/len0/data0     requester 0 request, burst length-1, byte
//   req1/len1/data1     requester 1 request, burst length-1, byte
//   gnt0, gnt1          registered ownership flags (never both high)
//   sel                 registered mux select (0 = data0, 1 = data1)
//   out_data, out_valid selected byte and its valid (combinational)
//   out_ready           downstream accepts the byte
//   beat_last           current beat is the final beat of the burst
//   busy                registered, high while not IDLE
//   timeout             (ARB_TIMEOUT_EN only) one-cycle pulse on forced release

module mux_bus_arbiter #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [LEN_W-1:0] len0,
    input  logic [7:0]       data0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             beat_last,
    output logic             busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             ptr;
    logic             ptr_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic             owning;
    logic             accept;
    logic             stall_hit;

    assign owning    = (state == OWN0) || (state == OWN1);
    assign out_valid = ((state == OWN0) && req0) || ((state == OWN1) && req1);
    assign out_data  = sel ? data1 : data0;
    assign accept    = out_valid && out_ready;
    assign beat_last = owning && (cnt == '0);

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall;

    // A beat accepted in the same cycle wins over the timeout.
    assign stall_hit = owning && !accept && (stall == STALL_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= stall_hit;
            // IDLE covers "entry into OWN": the count starts from zero on the first owned cycle.
            if (!owning || accept) begin
                stall <= '0;
            end else if (!stall_hit) begin
                stall <= stall + STALL_W'(1);
            end
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                // With both requesting, ptr=0 favours requester 0.
                if (req0 && (!req1 || !ptr)) begin
                    state_nxt = OWN0;
                    cnt_nxt   = len0;
                end else if (req1) begin
                    state_nxt = OWN1;
                    cnt_nxt   = len1;
                end
            end
            OWN0, OWN1: begin
                if (stall_hit) begin
                    state_nxt = IDLE;
                    ptr_nxt   = (state == OWN0);
                end else if (accept) begin
                    if (cnt == '0) begin
                        state_nxt = IDLE;
                        ptr_nxt   = (state == OWN0);
                    end else begin
                        cnt_nxt = cnt - LEN_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so they decode the state
    // exactly. In IDLE, sel keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            cnt   <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            sel   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            gnt0  <= (state_nxt == OWN0);
            gnt1  <= (state_nxt == OWN1);
            busy  <= (state_nxt != IDLE);
            if (state_nxt == OWN0) begin
                sel <= 1'b0;
            end else if (state_nxt == OWN1) begin
                sel <= 1'b1;
            end
        end
    end

endmodule
